nonce_gen_mc: RTL and testbench

NONCE_GEN_MC -- requirements
Module: nonce_gen_mc

---
 rtl/nonce_gen_mc.sv | 170 +++++++++++++++++
 tb/tb_nonce_gen_mc.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nonce_gen_mc.sv
// rtl/nonce_gen_mc.sv - nonce generator feeding 80-byte header frames to hash-core lanes
// Loads a 20-word header, then round-robins one frame (11 hash words + 1 nonce) per nonce.
module nonce_gen_mc #(
  parameter int NUM_LANES  = 4,
  parameter int NONCE_COEF = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      stop,
  input  logic [31:0]               hdr_word,
  input  logic                      hdr_we,
  input  logic [31:0]               nonce_size,
  input  logic [NUM_LANES-1:0]      hashin_full,
  output logic [NUM_LANES-1:0]      hashin_we,
  output logic [64*NUM_LANES-1:0]   hashin_din,
  input  logic [NUM_LANES-1:0]      nonce_full,
  output logic [NUM_LANES-1:0]      nonce_we,
  output logic [32*NUM_LANES-1:0]   nonce_din,
  output logic                      idle,
  output logic                      done,
  output logic [31:0]               nonce_end
);

  localparam int              PW        = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam logic [63:0]     PAD_WORD  = 64'h8000_0000_0000_0280;
  localparam logic [36:0]     COEF_W    = 37'(NONCE_COEF);
  localparam logic [31:0]     COEF_M1   = 32'(NONCE_COEF - 1);
  localparam logic [32:0]     END_MAX   = 33'h1_0000_0000;
  localparam logic [PW-1:0]   LAST_LANE = PW'(NUM_LANES - 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CALC, S_DISPATCH, S_BURST} state_t;

  state_t        state_q, state_d;
  logic [639:0]  hdr_q, hdr_d;
  logic [639:0]  frame_q, frame_d;
  logic [32:0]   cur_q, cur_d;
  logic [32:0]   end_q, end_d;
  logic [4:0]    cnt_q, cnt_d;
  logic [PW-1:0] p_q, p_d;

  logic [36:0]   span;
  logic [36:0]   end_full;
  logic [PW-1:0] p_next;
  logic          lane_hfull, lane_nfull;
  logic          h_we, n_we;
  logic [63:0]   h_din;
  logic [31:0]   n_din;

  assign idle       = (state_q == S_IDLE);
  assign nonce_end  = end_q[31:0];
  assign p_next     = (p_q == LAST_LANE) ? '0 : p_q + PW'(1);
  assign lane_hfull = hashin_full[p_q];
  assign lane_nfull = nonce_full[p_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      hdr_q   <= '0;
      frame_q <= '0;
      cur_q   <= '0;
      end_q   <= '0;
      cnt_q   <= '0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      hdr_q   <= hdr_d;
      frame_q <= frame_d;
      cur_q   <= cur_d;
      end_q   <= end_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    hdr_d    = hdr_q;
    frame_d  = frame_q;
    cur_d    = cur_q;
    end_d    = end_q;
    cnt_d    = cnt_q;
    p_d      = p_q;
    h_we     = 1'b0;
    h_din    = '0;
    n_we     = 1'b0;
    n_din    = '0;
    done     = 1'b0;
    // Wide sum so that an end past 2^32 can be detected before clamping.
    span     = {5'd0, nonce_size} * COEF_W;
    end_full = {5'd0, hdr_q[31:0]} + span;

    case (state_q)
      S_IDLE: begin
        hdr_d = '0;
        cur_d = '0;
        cnt_d = '0;
        p_d   = '0;
        if (start) state_d = S_LOAD;
      end
      S_LOAD: begin
        if (hdr_we) begin
          hdr_d = {hdr_word, hdr_q[639:32]};
          if (cnt_q == 5'd19) begin
            cnt_d   = '0;
            state_d = S_CALC;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
      end
      S_CALC: begin
        end_d   = (end_full > {4'd0, END_MAX}) ? END_MAX : end_full[32:0];
        cur_d   = {1'b0, hdr_q[31:0] + nonce_size * COEF_M1};
        state_d = S_DISPATCH;
      end
      S_DISPATCH: begin
        if (stop) begin
          state_d = S_IDLE;
        end else if (cur_q >= end_q) begin
          done    = 1'b1;
          state_d = S_IDLE;
        end else if (!lane_hfull && !lane_nfull) begin
          h_we    = 1'b1;
          h_din   = PAD_WORD;
          n_we    = 1'b1;
          n_din   = cur_q[31:0];
          frame_d = {hdr_q[639:32], cur_q[31:0]};
          cur_d   = cur_q + 33'd1;
          cnt_d   = '0;
          state_d = S_BURST;
        end else begin
          p_d = p_next;
        end
      end
      S_BURST: begin
        // Frame drains MSB-first; stop is deliberately not sampled here.
        if (!lane_hfull) begin
          h_we    = 1'b1;
          h_din   = frame_q[639:576];
          frame_d = {frame_q[575:0], 64'd0};
          if (cnt_q == 5'd9) begin
            cnt_d   = '0;
            p_d     = p_next;
            state_d = S_DISPATCH;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    hashin_we  = '0;
    hashin_din = '0;
    nonce_we   = '0;
    nonce_din  = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (PW'(i) == p_q) begin
        hashin_we[i]           = h_we;
        hashin_din[64*i +: 64] = h_din;
        nonce_we[i]            = n_we;
        nonce_din[32*i +: 32]  = n_din;
      end
    end
  end

endmodule

// File: tb/tb_nonce_gen_mc.sv
// tb/tb_nonce_gen_mc.sv - scoreboard bench for nonce_gen_mc
module tb_nonce_gen_mc;

  localparam int NL = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst, start, start2, stop, stop2, hdr_we;
  logic [31:0]      hdr_word, nonce_size;
  logic [NL-1:0]    hashin_full, nonce_full, full2;
  logic [NL-1:0]    hashin_we, nonce_we, h2_we, n2_we;
  logic [64*NL-1:0] hashin_din, h2_din;
  logic [32*NL-1:0] nonce_din, n2_din;
  logic             idle, done, idle2, done2;
  logic [31:0]      nonce_end, nonce_end2;

  nonce_gen_mc #(.NUM_LANES(NL), .NONCE_COEF(1)) u_dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .hdr_word(hdr_word), .hdr_we(hdr_we), .nonce_size(nonce_size),
    .hashin_full(hashin_full), .hashin_we(hashin_we), .hashin_din(hashin_din),
    .nonce_full(nonce_full), .nonce_we(nonce_we), .nonce_din(nonce_din),
    .idle(idle), .done(done), .nonce_end(nonce_end)
  );

  nonce_gen_mc #(.NUM_LANES(NL), .NONCE_COEF(2)) u_dut2 (
    .clk(clk), .rst(rst), .start(start2), .stop(stop2),
    .hdr_word(hdr_word), .hdr_we(hdr_we), .nonce_size(nonce_size),
    .hashin_full(full2), .hashin_we(h2_we), .hashin_din(h2_din),
    .nonce_full(full2), .nonce_we(n2_we), .nonce_din(n2_din),
    .idle(idle2), .done(done2), .nonce_end(nonce_end2)
  );

  typedef struct {
    int          lane;
    logic [63:0] data;
  } exp_t;

  exp_t        exp_h[$];
  exp_t        exp_n[$];
  exp_t        exp_n2[$];
  logic [31:0] hdr_w[20];
  int          vectors = 0;
  int          miscompares = 0;
  int          done_cnt = 0;
  int          done2_cnt = 0;
  int          h2_cnt = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, want);
    end
  endtask

  function automatic logic [63:0] frame_word(input int k, input logic [31:0] nonce);
    if (k == 0) return 64'h8000_0000_0000_0280;
    return {hdr_w[21-2*k], (k == 10) ? nonce : hdr_w[20-2*k]};
  endfunction

  task automatic set_header(input logic [31:0] base, input logic [7:0] tag);
    hdr_w[0] = base;
    for (int i = 1; i < 20; i++) hdr_w[i] = {tag, 8'h5A, 8'(i), 8'(i * 3)};
  endtask

  task automatic push_frame(input int lane, input logic [31:0] nonce, input int nwords);
    exp_t e;
    for (int k = 0; k < nwords; k++) begin
      e.lane = lane;
      e.data = frame_word(k, nonce);
      exp_h.push_back(e);
    end
    e.lane = lane;
    e.data = {32'd0, nonce};
    exp_n.push_back(e);
  endtask

  task automatic load_job(input bit second);
    @(posedge clk); #1;
    if (second) start2 = 1'b1; else start = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    start2 = 1'b0;
    for (int i = 0; i < 20; i++) begin
      hdr_we   = 1'b1;
      hdr_word = hdr_w[i];
      @(posedge clk); #1;
    end
    hdr_we = 1'b0;
  endtask

  task automatic wait_idle(input bit second, input int budget, input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(second ? idle2 : idle) && n < budget);
    chk({name, "_reach_idle"}, 64'(second ? idle2 : idle), 64'd1);
  endtask

  task automatic wait_lane_writes(input int lane, input int count, input string name);
    int seen = 0;
    int n = 0;
    while (seen < count && n < 400) begin
      @(negedge clk);
      n++;
      if (hashin_we[lane]) seen++;
    end
    chk({name, "_lane_writes"}, 64'(seen), 64'(count));
  endtask

  task automatic end_job(input string name, input int d0, input int ndone, input logic [31:0] nend);
    chk({name, "_done_pulses"}, 64'(done_cnt - d0), 64'(ndone));
    chk({name, "_nonce_end"}, 64'(nonce_end), 64'(nend));
    chk({name, "_hash_left"}, 64'(exp_h.size()), 64'd0);
    chk({name, "_nonce_left"}, 64'(exp_n.size()), 64'd0);
  endtask

  task automatic check_quiet(input string name);
    chk({name, "_idle"}, 64'(idle), 64'd1);
    chk({name, "_done"}, 64'(done), 64'd0);
    chk({name, "_we"}, 64'({hashin_we, nonce_we}), 64'd0);
    chk({name, "_din"}, 64'(|{hashin_din, nonce_din}), 64'd0);
    chk({name, "_nonce_end"}, 64'(nonce_end), 64'd0);
  endtask

  // Monitor for the COEF=1 instance: pops the scoreboard on every write.
  always @(negedge clk) begin
    logic bad_din;
    exp_t e;
    bad_din = 1'b0;
    chk("hash_onehot", 64'($countones(hashin_we) <= 1), 64'd1);
    chk("hash_we_while_full", 64'(hashin_we & hashin_full), 64'd0);
    chk("nonce_we_while_full", 64'(nonce_we & nonce_full), 64'd0);
    for (int i = 0; i < NL; i++) begin
      if (hashin_we[i]) begin
        if (exp_h.size() == 0) begin
          chk("hash_unexpected_lane", 64'(i), 64'hFFFF_FFFF);
        end else begin
          e = exp_h.pop_front();
          chk("hash_lane", 64'(i), 64'(e.lane));
          chk("hash_word", hashin_din[64*i +: 64], e.data);
        end
      end else if (hashin_din[64*i +: 64] != 64'd0) begin
        bad_din = 1'b1;
      end
      if (nonce_we[i]) begin
        if (exp_n.size() == 0) begin
          chk("nonce_unexpected_lane", 64'(i), 64'hFFFF_FFFF);
        end else begin
          e = exp_n.pop_front();
          chk("nonce_lane", 64'(i), 64'(e.lane));
          chk("nonce_value", 64'(nonce_din[32*i +: 32]), e.data);
        end
      end else if (nonce_din[32*i +: 32] != 32'd0) begin
        bad_din = 1'b1;
      end
    end
    chk("din_without_we", 64'(bad_din), 64'd0);
    if (done) done_cnt++;
  end

  // Monitor for the COEF=2 instance.
  always @(negedge clk) begin
    exp_t e;
    for (int i = 0; i < NL; i++) begin
      if (h2_we[i]) h2_cnt++;
      if (n2_we[i]) begin
        if (exp_n2.size() == 0) begin
          chk("dut2_unexpected_lane", 64'(i), 64'hFFFF_FFFF);
        end else begin
          e = exp_n2.pop_front();
          chk("dut2_nonce", {32'(i), n2_din[32*i +: 32]}, {32'(e.lane), e.data[31:0]});
        end
      end
    end
    if (done2) done2_cnt++;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   d0;
    exp_t e;
    rst = 1'b1; start = 1'b0; start2 = 1'b0; stop = 1'b0; stop2 = 1'b0;
    hdr_we = 1'b0; hdr_word = '0; nonce_size = '0;
    hashin_full = '0; nonce_full = '0; full2 = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_quiet("reset");

    // 8 nonces round-robin over 4 lanes
    set_header(32'h0000_0010, 8'h01);
    nonce_size = 32'd8;
    for (int i = 0; i < 8; i++) push_frame(i % 4, 32'h10 + 32'(i), 11);
    d0 = done_cnt;
    load_job(1'b0);
    wait_idle(1'b0, 1000, "basic");
    end_job("basic", d0, 1, 32'h18);

    // COEF=2 slice: 0x100..0x1FF
    set_header(32'h0000_0000, 8'h02);
    nonce_size = 32'h100;
    for (int i = 0; i < 256; i++) begin
      e.lane = i % 4;
      e.data = 64'(32'h100 + 32'(i));
      exp_n2.push_back(e);
    end
    h2_cnt = 0;
    d0 = done2_cnt;
    load_job(1'b1);
    wait_idle(1'b1, 5000, "coef2");
    chk("coef2_hash_words", 64'(h2_cnt), 64'd2816);
    chk("coef2_done_pulses", 64'(done2_cnt - d0), 64'd1);
    chk("coef2_nonce_end", 64'(nonce_end2), 64'h200);
    chk("coef2_nonce_left", 64'(exp_n2.size()), 64'd0);

    // End clamps to 2^32: only 0xFFFFFFFE and 0xFFFFFFFF
    set_header(32'hFFFF_FFFE, 8'h03);
    nonce_size = 32'd4;
    push_frame(0, 32'hFFFF_FFFE, 11);
    push_frame(1, 32'hFFFF_FFFF, 11);
    d0 = done_cnt;
    load_job(1'b0);
    wait_idle(1'b0, 1000, "wrap");
    end_job("wrap", d0, 1, 32'h0);

    // Empty range: done with no writes
    set_header(32'h0000_0050, 8'h04);
    nonce_size = 32'd0;
    d0 = done_cnt;
    load_job(1'b0);
    wait_idle(1'b0, 100, "empty");
    end_job("empty", d0, 1, 32'h50);

    // Lane 1 nonce FIFO full; lane 0 stalls 3 cycles at word 5
    set_header(32'h0000_0100, 8'h05);
    nonce_size = 32'd6;
    nonce_full = 4'b0010;
    push_frame(0, 32'h100, 11);
    push_frame(2, 32'h101, 11);
    push_frame(3, 32'h102, 11);
    push_frame(0, 32'h103, 11);
    push_frame(2, 32'h104, 11);
    push_frame(3, 32'h105, 11);
    d0 = done_cnt;
    load_job(1'b0);
    wait_lane_writes(0, 5, "stall");
    @(posedge clk); #1 hashin_full[0] = 1'b1;
    repeat (3) @(posedge clk);
    #1 hashin_full[0] = 1'b0;
    wait_idle(1'b0, 1000, "stall");
    end_job("stall", d0, 1, 32'h106);
    nonce_full = '0;

    // stop during word 4: frame completes, no done
    set_header(32'h0000_0200, 8'h06);
    nonce_size = 32'd8;
    push_frame(0, 32'h200, 11);
    d0 = done_cnt;
    load_job(1'b0);
    wait_lane_writes(0, 4, "stop");
    @(posedge clk); #1 stop = 1'b1;
    wait_idle(1'b0, 100, "stop");
    stop = 1'b0;
    end_job("stop", d0, 0, 32'h208);

    // rst during word 3 abandons the frame
    set_header(32'h0000_0300, 8'h07);
    nonce_size = 32'd4;
    push_frame(0, 32'h300, 4);
    load_job(1'b0);
    wait_lane_writes(0, 3, "rst");
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check_quiet("rst_mid_burst");
    chk("rst_hash_left", 64'(exp_h.size()), 64'd0);

    set_header(32'h0000_0400, 8'h08);
    nonce_size = 32'd2;
    push_frame(0, 32'h400, 11);
    push_frame(1, 32'h401, 11);
    d0 = done_cnt;
    load_job(1'b0);
    wait_idle(1'b0, 1000, "after_rst");
    end_job("after_rst", d0, 1, 32'h402);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
